// File: rtl/ipid_rx_pkg.sv
// ipid_rx_pkg
// Shared types and defaults for the IP ID receive deframer (ipid_gpio_rx).
//   state_t    : deframer FSM states
//   err_code_t : abort reason reported on err_code
//   *_DEFAULT  : frame delimiters and geometry defaults
package ipid_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_TRAILER = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TRAILER = 2'd1,
    ERR_ABORT   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam int unsigned NUM_IP_DEFAULT       = 16;
  localparam int unsigned WORD_W_DEFAULT       = 16;
  localparam int unsigned WORDS_PER_ID_DEFAULT = 16;
  localparam int unsigned TIMEOUT_DEFAULT      = 4096;
  localparam logic [15:0] HDR_DEFAULT          = 16'h7A7A;
  localparam logic [15:0] TRL_DEFAULT          = 16'hB9B9;

endpackage

// File: rtl/ipid_gpio_rx.sv
// ipid_gpio_rx
// Receive-side deframer collecting one 256-bit IP ID per slot over a 16-bit
// GPIO lane during secure boot.
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   start          one-cycle run start (honoured in IDLE/DONE/ERROR only)
//   gpio_word_in   GPIO data lane
//   gpio_valid_in  host frame-active strobe
//   trigger_out    IP ID trigger to host (ARM/CAPTURE/TRAILER)
//   ip_addr_out    current slot index
//   ipid_valid     one-cycle strobe qualifying ipid_data/ipid_idx
//   ipid_idx       slot index of the delivered IP ID
//   ipid_data      assembled IP ID, first payload word in the MSBs
//   done           level: all slots delivered, cleared by start
//   error          level: run aborted, cleared by start
//   err_code       abort reason (see err_code_t)
module ipid_gpio_rx
  import ipid_rx_pkg::*;
#(
  parameter int unsigned NUM_IP       = NUM_IP_DEFAULT,
  parameter int unsigned WORD_W       = WORD_W_DEFAULT,
  parameter int unsigned WORDS_PER_ID = WORDS_PER_ID_DEFAULT,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT,
  parameter logic [WORD_W-1:0] HDR    = WORD_W'(HDR_DEFAULT),
  parameter logic [WORD_W-1:0] TRL    = WORD_W'(TRL_DEFAULT),
  localparam int unsigned IPID_W      = WORD_W * WORDS_PER_ID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] gpio_word_in,
  input  logic              gpio_valid_in,
  output logic              trigger_out,
  output logic [3:0]        ip_addr_out,
  output logic              ipid_valid,
  output logic [3:0]        ipid_idx,
  output logic [IPID_W-1:0] ipid_data,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned WCNT_W = (WORDS_PER_ID > 1) ? $clog2(WORDS_PER_ID) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0]        SLOT_LAST = 4'(NUM_IP - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_ID - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t              state;
  err_code_t           err_q;
  logic [3:0]          slot;
  logic [WCNT_W-1:0]   wcnt;
  logic [TCNT_W-1:0]   tcnt;
  logic [IPID_W-1:0]   sreg;
  logic [IPID_W-1:0]   sreg_shifted;
  logic                hdr_seen;
  logic                trl_seen;
  logic                tmo_hit;

  // Oldest word migrates toward the MSBs as newer words enter at the bottom.
  assign sreg_shifted = {sreg[IPID_W-WORD_W-1:0], gpio_word_in};
  assign hdr_seen     = gpio_valid_in && (gpio_word_in == HDR);
  assign trl_seen     = gpio_word_in == TRL;
  assign tmo_hit      = tcnt == TCNT_LAST;

  assign trigger_out = (state == ST_ARM) || (state == ST_CAPTURE) ||
                       (state == ST_TRAILER);
  assign ip_addr_out = slot;
  assign err_code    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      err_q      <= ERR_NONE;
      slot       <= '0;
      wcnt       <= '0;
      tcnt       <= '0;
      sreg       <= '0;
      ipid_data  <= '0;
      ipid_idx   <= '0;
      ipid_valid <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      ipid_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            err_q <= ERR_NONE;
            slot  <= '0;
            tcnt  <= '0;
            state <= ST_ARM;
          end
        end

        // Non-header valid words are dropped (resync); the wait budget keeps
        // running across them. Timeout takes priority over a coincident header.
        ST_ARM: begin
          if (tmo_hit) begin
            tcnt  <= '0;
            error <= 1'b1;
            err_q <= ERR_TIMEOUT;
            state <= ST_ERROR;
          end else if (hdr_seen) begin
            tcnt  <= '0;
            wcnt  <= '0;
            state <= ST_CAPTURE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        ST_CAPTURE: begin
          if (!gpio_valid_in) begin
            error <= 1'b1;
            err_q <= ERR_ABORT;
            state <= ST_ERROR;
          end else begin
            sreg <= sreg_shifted;
            wcnt <= wcnt + WCNT_W'(1);
            if (wcnt == WCNT_LAST) begin
              state <= ST_TRAILER;
            end
          end
        end

        ST_TRAILER: begin
          if (!gpio_valid_in) begin
            error <= 1'b1;
            err_q <= ERR_ABORT;
            state <= ST_ERROR;
          end else if (!trl_seen) begin
            error <= 1'b1;
            err_q <= ERR_TRAILER;
            state <= ST_ERROR;
          end else begin
            ipid_data  <= sreg;
            ipid_idx   <= slot;
            ipid_valid <= 1'b1;
            tcnt       <= '0;
            state      <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (tmo_hit) begin
            tcnt  <= '0;
            error <= 1'b1;
            err_q <= ERR_TIMEOUT;
            state <= ST_ERROR;
          end else if (!gpio_valid_in) begin
            tcnt <= '0;
            if (slot == SLOT_LAST) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              slot  <= slot + 4'd1;
              state <= ST_ARM;
            end
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipid_gpio_rx.sv
module tb_ipid_gpio_rx;
  import ipid_rx_pkg::*;

  localparam int unsigned NUM_IP  = 16;
  localparam int unsigned WPI     = 16;
  localparam int unsigned TIMEOUT = 4096;
  localparam logic [15:0] HDR     = 16'h7A7A;
  localparam logic [15:0] TRL     = 16'hB9B9;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  gpio_word_in;
  logic         gpio_valid_in;
  logic         trigger_out;
  logic [3:0]   ip_addr_out;
  logic         ipid_valid;
  logic [3:0]   ipid_idx;
  logic [255:0] ipid_data;
  logic         done;
  logic         error;
  logic [1:0]   err_code;

  ipid_gpio_rx #(
    .NUM_IP(NUM_IP), .WORD_W(16), .WORDS_PER_ID(WPI),
    .TIMEOUT(TIMEOUT), .HDR(HDR), .TRL(TRL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .gpio_word_in(gpio_word_in), .gpio_valid_in(gpio_valid_in),
    .trigger_out(trigger_out), .ip_addr_out(ip_addr_out),
    .ipid_valid(ipid_valid), .ipid_idx(ipid_idx), .ipid_data(ipid_data),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [255:0] data;
  } exp_t;

  exp_t exp_q[$];
  int unsigned vec_cnt  = 0;
  int unsigned err_cnt  = 0;
  int unsigned n_pulses = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Delivery scoreboard: every ipid_valid pulse must match the oldest
  // frame the bench has sent with a good trailer.
  always @(negedge clk) begin
    if (rst === 1'b1 && ipid_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("spurious_ipid_valid", ipid_valid, 256'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ipid_idx", ipid_idx, e.idx);
        check("ipid_data", ipid_data, e.data);
      end
    end
  end

  // Drive a lane value now; return at the negedge after the edge sampled it.
  task automatic step(input logic v, input logic [15:0] w);
    gpio_valid_in = v;
    gpio_word_in  = w;
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_trigger"}, trigger_out, 0);
    check({pfx, "_addr"}, ip_addr_out, 0);
    check({pfx, "_ipid_valid"}, ipid_valid, 0);
    check({pfx, "_ipid_idx"}, ipid_idx, 0);
    check({pfx, "_ipid_data"}, ipid_data, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_err_code"}, err_code, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    gpio_valid_in = 1'b0;
    gpio_word_in = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
  endtask

  task automatic send_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_trigger", trigger_out, 1);
    check("start_addr", ip_addr_out, 0);
  endtask

  // One complete good slot: optional idle gap, header, payload, trailer,
  // optional valid-high hold in release, then valid low.
  task automatic run_slot(input int unsigned s, input int unsigned gap, input int unsigned hold);
    logic [15:0]  w[WPI];
    logic [255:0] d;
    exp_t         e;
    d = '0;
    for (int unsigned i = 0; i < WPI; i++) begin
      w[i] = 16'($urandom);
      d[255 - 16*i -: 16] = w[i];
    end
    check("arm_trigger", trigger_out, 1);
    check("arm_addr", ip_addr_out, 4'(s));
    repeat (gap) step(1'b0, 16'($urandom));
    step(1'b1, HDR);
    for (int unsigned i = 0; i < WPI; i++) step(1'b1, w[i]);
    e.idx = 4'(s);
    e.data = d;
    exp_q.push_back(e);
    step(1'b1, TRL);
    check("deliver_valid", ipid_valid, 1);
    check("deliver_trigger_low", trigger_out, 0);
    check("deliver_done_low", done, 0);
    repeat (hold) begin
      step(1'b1, 16'($urandom));
      check("release_trigger_low", trigger_out, 0);
    end
    step(1'b0, 16'h0);
    if (s == NUM_IP - 1) begin
      check("done_set", done, 1);
      check("done_error", error, 0);
      check("done_trigger", trigger_out, 0);
    end else begin
      check("next_trigger", trigger_out, 1);
      check("next_addr", ip_addr_out, 4'(s + 1));
    end
  endtask

  task automatic full_run();
    n_pulses = 0;
    send_start();
    for (int unsigned s = 0; s < NUM_IP; s++)
      run_slot(s, $urandom_range(0, 3), $urandom_range(0, 2));
    step(1'b0, 16'h0);
    check("pulse_count", n_pulses, NUM_IP);
    check("pending_ids", exp_q.size(), 0);
    check("run_done", done, 1);
    check("run_error", error, 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    gpio_valid_in = 1'b0;
    gpio_word_in = '0;

    // Full run with random payloads
    do_reset();
    full_run();

    // Resync: junk valid words in ARM are ignored
    do_reset();
    send_start();
    step(1'b1, 16'h1234);
    step(1'b1, 16'h5555);
    check("resync_no_error", error, 0);
    run_slot(0, 0, 0);
    check("resync_pending", exp_q.size(), 0);

    // Bad trailer
    do_reset();
    n_pulses = 0;
    send_start();
    step(1'b1, HDR);
    for (int unsigned i = 0; i < WPI; i++) step(1'b1, 16'($urandom));
    step(1'b1, 16'hB9B8);
    check("badtrl_error", error, 1);
    check("badtrl_code", err_code, ERR_TRAILER);
    check("badtrl_valid", ipid_valid, 0);
    check("badtrl_trigger", trigger_out, 0);
    step(1'b0, 16'h0);
    check("badtrl_pulses", n_pulses, 0);

    // Frame abort after 9 payload words
    do_reset();
    send_start();
    step(1'b1, HDR);
    for (int unsigned i = 0; i < 9; i++) step(1'b1, 16'($urandom));
    step(1'b0, 16'h0);
    check("abort_error", error, 1);
    check("abort_code", err_code, ERR_ABORT);
    check("abort_trigger", trigger_out, 0);

    // Timeout: no header ever arrives
    do_reset();
    send_start();
    repeat (TIMEOUT - 1) step(1'b0, 16'h0);
    check("tmo_early_code", err_code, ERR_NONE);
    check("tmo_early_trigger", trigger_out, 1);
    step(1'b0, 16'h0);
    check("tmo_code", err_code, ERR_TIMEOUT);
    check("tmo_error", error, 1);
    check("tmo_trigger", trigger_out, 0);

    // Start from ERROR clears the error state
    send_start();
    check("restart_error", error, 0);
    check("restart_code", err_code, ERR_NONE);

    // Asynchronous reset mid-frame in slot 5, then a clean run
    do_reset();
    send_start();
    for (int unsigned s = 0; s < 5; s++) run_slot(s, 0, 0);
    step(1'b1, HDR);
    for (int unsigned i = 0; i < 8; i++) step(1'b1, 16'($urandom));
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    gpio_valid_in = 1'b0;
    rst = 1'b1;
    full_run();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
